// File: rtl/afifo_rd_packer.sv
// Read-side drain stage for the afifo: pops bytes, absorbs the one-cycle r_data latency,
// packs pack_ratio bytes little-endian into a valid/ready word and flushes partial words after idle.
module afifo_rd_packer #(
   parameter int unsigned data_width   = 8,
   parameter int unsigned pack_ratio   = 2,
   parameter int unsigned flush_cycles = 16
) (
   input  logic                             r_clk,
   input  logic                             clr_n,
   input  logic                             empty,
   input  logic [data_width-1:0]            r_data,
   output logic                             read_en,
   output logic [data_width*pack_ratio-1:0] out_data,
   output logic [pack_ratio-1:0]            out_keep,
   output logic                             out_valid,
   input  logic                             out_ready
);

   localparam int unsigned WORD_W = data_width * pack_ratio;
   localparam int unsigned CNT_W  = $clog2(pack_ratio + 1);
   localparam int unsigned SUM_W  = CNT_W + 1;
   localparam int unsigned TMR_W  = 8;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(pack_ratio);
   localparam logic [TMR_W-1:0] TMR_LIM  = TMR_W'(flush_cycles);
   localparam logic             FLUSH_EN = (flush_cycles != 0);

   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              pend;
   logic [TMR_W-1:0]  timer;
   logic [TMR_W-1:0]  timer_nxt;
   logic [WORD_W-1:0] pack;
   logic [WORD_W-1:0] pack_nxt;
   logic [CNT_W-1:0]  lane;
   logic [pack_ratio-1:0] keep_nxt;
   logic slot_free;
   logic xfer_full;
   logic flush_pend;
   logic flush_go;
   logic xfer;
   logic cnt_partial;

   // Transfer decisions and the pop request
   always_comb begin
      slot_free   = !out_valid | out_ready;
      xfer_full   = (cnt == CNT_FULL) & slot_free;
      flush_pend  = FLUSH_EN & (timer == TMR_LIM);
      // A byte landing in the flush cycle completes the word instead of being split off
      flush_go    = flush_pend & !pend & slot_free;
      xfer        = xfer_full | flush_go;
      cnt_partial = (cnt != '0) & (cnt < CNT_FULL);
      read_en     = clr_n & !empty & !flush_pend &
                    (((SUM_W'(cnt) + SUM_W'(pend)) < SUM_W'(pack_ratio)) | xfer_full);
   end

   // Packing register, fill count, idle timer and keep mask next-state
   always_comb begin
      pack_nxt  = xfer ? '0 : pack;
      lane      = xfer ? '0 : cnt;
      cnt_nxt   = (xfer ? '0 : cnt) + CNT_W'(pend);
      timer_nxt = timer;
      keep_nxt  = '0;
      for (int unsigned i = 0; i < pack_ratio; i++) begin
         if (pend && (lane == CNT_W'(i)))
            pack_nxt[i*data_width +: data_width] = r_data;
         keep_nxt[i] = (CNT_W'(i) < cnt);
      end
      if (xfer || pend)
         timer_nxt = '0;
      else if (cnt_partial && (timer != TMR_LIM))
         timer_nxt = timer + TMR_W'(1);
   end

   always_ff @(posedge r_clk or negedge clr_n) begin
      if (!clr_n) begin
         cnt       <= '0;
         pend      <= 1'b0;
         timer     <= '0;
         pack      <= '0;
         out_data  <= '0;
         out_keep  <= '0;
         out_valid <= 1'b0;
      end else begin
         cnt   <= cnt_nxt;
         pend  <= read_en;
         timer <= timer_nxt;
         pack  <= pack_nxt;
         if (xfer) begin
            out_data  <= pack;
            out_keep  <= keep_nxt;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
